// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - PRBS7 constants, checker FSM state type and popcount helper
// Contents: TAP_A/TAP_B feedback taps (6,5), PRBS_ORDER=7, WORD_W=8,
//           prbs_state_t {SEARCH, VERIFY, LOCKED}, popcount8().
package prbs_pkg;

  localparam int TAP_A      = 6;
  localparam int TAP_B      = 5;
  localparam int PRBS_ORDER = 7;
  localparam int WORD_W     = 8;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_t;

  function automatic logic [3:0] popcount8(input logic [WORD_W-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < WORD_W; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/prbs7_word_step.sv
// rtl/prbs7_word_step.sv - combinational 8-bit advance of a PRBS7 (x^7+x^6+1) state
// Ports: state_in  (7)  current predictor state, bit 6 oldest
//        word_out  (8)  next 8 generated bits, first generated bit at bit 7
//        state_out (7)  predictor state after those 8 bits
module prbs7_word_step
  import prbs_pkg::*;
(
  input  logic [PRBS_ORDER-1:0] state_in,
  output logic [WORD_W-1:0]     word_out,
  output logic [PRBS_ORDER-1:0] state_out
);

  logic [PRBS_ORDER-1:0] s;
  logic                  b;

  always_comb begin
    s        = state_in;
    b        = 1'b0;
    word_out = '0;
    // Unrolled shift: each iteration produces one bit, oldest bit lands in word_out[7].
    for (int i = WORD_W - 1; i >= 0; i--) begin
      b           = s[TAP_A] ^ s[TAP_B];
      word_out[i] = b;
      s           = {s[PRBS_ORDER-2:0], b};
    end
    state_out = s;
  end

endmodule

// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - PRBS7 word checker with SEARCH/VERIFY/LOCKED lock FSM
// Ports: clk, reset (sync, active low), data_in[7:0] (bit 7 oldest), data_valid,
//        clear_cnt -> locked, err_pulse, bit_err_cnt[CNT_W], word_err_cnt[CNT_W]
//        word_cnt[CNT_W] only when PRBS7_CHECKER_WORD_CNT_EN is defined.
// Params: LOCK_CNT, UNLOCK_CNT, CNT_W (CNT_W >= 4).
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              clear_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  bit_err_cnt,
  output logic [CNT_W-1:0]  word_err_cnt
`ifdef PRBS7_CHECKER_WORD_CNT_EN
  ,
  output logic [CNT_W-1:0]  word_cnt
`endif
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int CERR_W  = $clog2(UNLOCK_CNT + 1);
  localparam int SUM_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  prbs_state_t           state_q, state_d;
  logic [PRBS_ORDER-1:0] pred_q, pred_d;
  logic [MATCH_W-1:0]    match_q, match_d;
  logic [CERR_W-1:0]     cerr_q, cerr_d;

  logic [WORD_W-1:0]     pred_word;
  logic [PRBS_ORDER-1:0] pred_next;
  logic [WORD_W-1:0]     diff;
  logic                  mismatch;
  logic                  lock_err;
  logic [3:0]            nbits;

  prbs7_word_step u_step (
    .state_in  (pred_q),
    .word_out  (pred_word),
    .state_out (pred_next)
  );

  assign diff     = data_in ^ pred_word;
  assign mismatch = |diff;
  assign nbits    = popcount8(diff);
  assign lock_err = data_valid && (state_q == LOCKED) && mismatch;

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    match_d = match_q;
    cerr_d  = cerr_q;
    if (data_valid) begin
      case (state_q)
        SEARCH: begin
          // The last 7 received bits are exactly the generator state; all-zero is not a PRBS state.
          if (data_in[PRBS_ORDER-1:0] != '0) begin
            pred_d  = data_in[PRBS_ORDER-1:0];
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          pred_d = pred_next;
          if (mismatch) begin
            state_d = SEARCH;
          end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            cerr_d  = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        LOCKED: begin
          // Free-running: the predictor is never reloaded from data_in here.
          pred_d = pred_next;
          if (!mismatch) begin
            cerr_d = '0;
          end else if (cerr_q == CERR_W'(UNLOCK_CNT - 1)) begin
            state_d = SEARCH;
            cerr_d  = '0;
          end else begin
            cerr_d = cerr_q + 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // A clear in the same cycle as an error leaves only that error's contribution.
  logic [CNT_W-1:0] bit_base, word_base, bit_sat, word_sat;
  logic [SUM_W-1:0] bit_sum;

  assign bit_base  = clear_cnt ? '0 : bit_err_cnt;
  assign word_base = clear_cnt ? '0 : word_err_cnt;
  assign bit_sum   = {1'b0, bit_base} + SUM_W'(nbits);
  assign bit_sat   = (bit_sum > {1'b0, CNT_MAX}) ? CNT_MAX : bit_sum[CNT_W-1:0];
  assign word_sat  = (word_base == CNT_MAX) ? CNT_MAX : word_base + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= SEARCH;
      pred_q       <= '1;
      match_q      <= '0;
      cerr_q       <= '0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      bit_err_cnt  <= '0;
      word_err_cnt <= '0;
    end else begin
      state_q   <= state_d;
      pred_q    <= pred_d;
      match_q   <= match_d;
      cerr_q    <= cerr_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= lock_err;
      if (lock_err) begin
        bit_err_cnt  <= bit_sat;
        word_err_cnt <= word_sat;
      end else if (clear_cnt) begin
        bit_err_cnt  <= '0;
        word_err_cnt <= '0;
      end
    end
  end

`ifdef PRBS7_CHECKER_WORD_CNT_EN
  logic             lock_word;
  logic [CNT_W-1:0] wc_base;

  assign lock_word = data_valid && (state_q == LOCKED);
  assign wc_base   = clear_cnt ? '0 : word_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      word_cnt <= '0;
    end else if (lock_word) begin
      word_cnt <= (wc_base == CNT_MAX) ? CNT_MAX : wc_base + 1'b1;
    end else if (clear_cnt) begin
      word_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_prbs7_checker.sv
// tb/tb_prbs7_checker.sv - scoreboard bench for prbs7_checker (CNT_W=16 and CNT_W=4 instances)
module tb_prbs7_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_valid = 1'b0;
  logic       clear_cnt = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic        locked16, pulse16, locked4, pulse4;
  logic [15:0] bit16, word16;
  logic [3:0]  bit4, word4;
`ifdef PRBS7_CHECKER_WORD_CNT_EN
  logic [15:0] wc16;
  logic [3:0]  wc4;
`endif

  always #5 clk = ~clk;

  prbs7_checker dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .clear_cnt(clear_cnt), .locked(locked16), .err_pulse(pulse16),
    .bit_err_cnt(bit16), .word_err_cnt(word16)
`ifdef PRBS7_CHECKER_WORD_CNT_EN
    , .word_cnt(wc16)
`endif
  );

  prbs7_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .clear_cnt(clear_cnt), .locked(locked4), .err_pulse(pulse4),
    .bit_err_cnt(bit4), .word_err_cnt(word4)
`ifdef PRBS7_CHECKER_WORD_CNT_EN
    , .word_cnt(wc4)
`endif
  );

  typedef struct packed {
    logic        locked;
    logic        pulse;
    logic [15:0] bit16;
    logic [15:0] word16;
    logic [3:0]  bit4;
    logic [3:0]  word4;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: bit-history form of the recurrence b[n] = b[n-7] ^ b[n-6].
  bit src_bits[$];
  bit m_bits[$];
  int m_mode;  // 0 search, 1 verify, 2 locked
  int m_match, m_cerr, m_bit16, m_word16, m_bit4, m_word4;
  bit m_pulse;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endfunction

  function automatic logic [7:0] src_next();
    logic [7:0] w;
    for (int i = 7; i >= 0; i--) begin
      w[i] = src_bits[src_bits.size() - 7] ^ src_bits[src_bits.size() - 6];
      src_bits.push_back(w[i]);
    end
    return w;
  endfunction

  function automatic logic [7:0] pred_next();
    logic [7:0] w;
    for (int i = 7; i >= 0; i--) begin
      w[i] = m_bits[m_bits.size() - 7] ^ m_bits[m_bits.size() - 6];
      m_bits.push_back(w[i]);
    end
    return w;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input logic rst_n, input logic v, input logic clr, input logic [7:0] d);
    bit         err;
    int         nerr;
    logic [7:0] p;
    exp_t       e;
    err  = 0;
    nerr = 0;
    if (!rst_n) begin
      m_mode = 0; m_match = 0; m_cerr = 0; m_pulse = 0;
      m_bit16 = 0; m_word16 = 0; m_bit4 = 0; m_word4 = 0;
      m_bits.delete();
      repeat (7) m_bits.push_back(1'b1);
    end else begin
      if (v) begin
        case (m_mode)
          0: if (d[6:0] != 7'd0) begin
               m_bits.delete();
               for (int i = 6; i >= 0; i--) m_bits.push_back(d[i]);
               m_mode = 1;
               m_match = 0;
             end
          1: begin
               p = pred_next();
               if (p != d) m_mode = 0;
               else begin
                 m_match++;
                 if (m_match == 4) begin m_mode = 2; m_cerr = 0; end
               end
             end
          default: begin
               p = pred_next();
               if (p != d) begin
                 err  = 1;
                 nerr = $countones(p ^ d);
                 m_cerr++;
                 if (m_cerr == 3) begin m_mode = 0; m_cerr = 0; end
               end else m_cerr = 0;
             end
        endcase
      end
      if (clr) begin
        m_bit16 = 0; m_word16 = 0; m_bit4 = 0; m_word4 = 0;
      end
      if (err) begin
        m_word16 = sat(m_word16 + 1, 65535);
        m_bit16  = sat(m_bit16 + nerr, 65535);
        m_word4  = sat(m_word4 + 1, 15);
        m_bit4   = sat(m_bit4 + nerr, 15);
      end
      m_pulse = err;
    end
    e.locked = (m_mode == 2);
    e.pulse  = m_pulse;
    e.bit16  = 16'(m_bit16);
    e.word16 = 16'(m_word16);
    e.bit4   = 4'(m_bit4);
    e.word4  = 4'(m_word4);
    expq.push_back(e);
  endtask

  task automatic drive(input logic rst_n, input logic v, input logic clr, input logic [7:0] d);
    @(negedge clk);
    reset      = rst_n;
    data_valid = v;
    clear_cnt  = clr;
    data_in    = d;
    model_step(rst_n, v, clr, d);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic clean(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b1, 1'b0, src_next());
  endtask

  // Monitor: each posedge consumes the expectation pushed for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("locked",       32'(locked16), 32'(e.locked));
        chk("err_pulse",    32'(pulse16),  32'(e.pulse));
        chk("bit_err_cnt",  32'(bit16),    32'(e.bit16));
        chk("word_err_cnt", 32'(word16),   32'(e.word16));
        chk("locked_w4",    32'(locked4),  32'(e.locked));
        chk("err_pulse_w4", 32'(pulse4),   32'(e.pulse));
        chk("bit_cnt_w4",   32'(bit4),     32'(e.bit4));
        chk("word_cnt_w4",  32'(word4),    32'(e.word4));
      end
    end
  end

  initial begin
    logic [7:0] w;
    int         r;
    src_bits = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};  // seed 7'h02, oldest first

    // Reset 2 cycles, overriding valid and clear.
    drive(1'b0, 1'b1, 1'b1, 8'hA5);
    drive(1'b0, 1'b1, 1'b1, 8'h3C);

    // Clean stream: locked rises one cycle after the 5th valid word.
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, src_next());
      settle();
      if (k == 4) chk("lock_not_yet", 32'(locked16), 32'd0);
      if (k == 5) chk("lock_at_5", 32'(locked16), 32'd1);
    end
    clean(95);
    settle();
    chk("clean_word_cnt", 32'(word16), 32'd0);
    chk("clean_bit_cnt", 32'(bit16), 32'd0);

    // Two-bit error in one word.
    drive(1'b1, 1'b1, 1'b0, src_next() ^ 8'h09);
    settle();
    chk("two_bit_pulse", 32'(pulse16), 32'd1);
    chk("two_bit_word", 32'(word16), 32'd1);
    chk("two_bit_bits", 32'(bit16), 32'd2);
    chk("two_bit_locked", 32'(locked16), 32'd1);
    clean(1);
    settle();
    chk("pulse_one_cycle", 32'(pulse16), 32'd0);

    // Clear coinciding with a 1-bit error.
    drive(1'b1, 1'b1, 1'b1, src_next() ^ (8'h01 << $urandom_range(7, 0)));
    settle();
    chk("clr_err_word", 32'(word16), 32'd1);
    chk("clr_err_bits", 32'(bit16), 32'd1);
    clean(3);

    // Three consecutive 1-bit errors unlock; relock after 5 clean words.
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, src_next() ^ (8'h01 << $urandom_range(7, 0)));
      settle();
      chk("unlock_locked", 32'(locked16), (k == 3) ? 32'd0 : 32'd1);
    end
    chk("unlock_word_cnt", 32'(word16), 32'd3);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b1, 1'b0, src_next());
      settle();
      if (k == 4) chk("relock_not_yet", 32'(locked16), 32'd0);
      if (k == 5) chk("relock_at_5", 32'(locked16), 32'd1);
    end

    // Saturation on the 4-bit instance: flip, flip, clean, flip.
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 1'b0, src_next() ^ 8'hFF);
    drive(1'b1, 1'b1, 1'b0, src_next() ^ 8'hFF);
    clean(1);
    drive(1'b1, 1'b1, 1'b0, src_next() ^ 8'hFF);
    settle();
    chk("sat_bit4", 32'(bit4), 32'd15);
    chk("sat_word4", 32'(word4), 32'd3);
    chk("sat_bit16", 32'(bit16), 32'd24);
    chk("sat_locked", 32'(locked4), 32'd1);

    // Reset mid-lock drops locked; relock with data_valid 1-of-3.
    drive(1'b0, 1'b1, 1'b0, src_next());
    settle();
    chk("reset_drops_lock", 32'(locked16), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'($urandom));
      drive(1'b1, 1'b0, 1'b0, 8'($urandom));
      drive(1'b1, 1'b1, 1'b0, src_next());
      settle();
      if (k == 4) chk("gap_not_yet", 32'(locked16), 32'd0);
      if (k == 5) chk("gap_lock_at_5", 32'(locked16), 32'd1);
    end

    // Randomized traffic: gaps, bit errors, clears, occasional reset.
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(199, 0);
      if (r == 0) drive(1'b0, 1'b1, 1'b0, 8'($urandom));
      else if ($urandom_range(3, 0) == 0) drive(1'b1, 1'b0, ($urandom_range(9, 0) == 0), 8'($urandom));
      else begin
        w = src_next();
        if ($urandom_range(11, 0) == 0) w = w ^ 8'($urandom_range(255, 1));
        drive(1'b1, 1'b1, ($urandom_range(19, 0) == 0), w);
      end
    end

    drive(1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    settle();
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs7_checker.md
PRBS7_CHECKER -- requirements
Module: prbs7_checker

Interface
REQ-001 The block SHALL provide parameter LOCK_CNT, default 4: consecutive matching words needed to declare lock.
REQ-002 The block SHALL provide parameter UNLOCK_CNT, default 3: consecutive errored words that drop lock.
REQ-003 The block SHALL provide parameter CNT_W, default 16: width of the error counters.
REQ-004 The block SHALL have port clk, in, 1: single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, in, 1: synchronous, active-low reset.
REQ-006 The block SHALL have port data_in, in, 8: received PRBS word; bit 7 is the oldest bit, bit 0 the newest.
REQ-007 The block SHALL have port data_valid, in, 1: data_in is sampled on every clk edge where this is high.
REQ-008 The block SHALL have port clear_cnt, in, 1: synchronous clear of both error counters.
REQ-009 The block SHALL have port locked, out, 1: the checker is in LOCKED.
REQ-010 The block SHALL have port err_pulse, out, 1: one-cycle pulse for a word that mismatches while in LOCKED.
REQ-011 The block SHALL have port bit_err_cnt, out, CNT_W: saturating count of errored bits in LOCKED.
REQ-012 The block SHALL have port word_err_cnt, out, CNT_W: saturating count of errored words in LOCKED.

Function
REQ-013 The predictor SHALL hold a 7-bit PRBS7 state s (x^7+x^6+1). Each new bit b = s[6]^s[5] and s <= {s[5:0],b}. A word is 8 successive bits, with the first bit at bit 7.
REQ-014 The FSM SHALL have three states: SEARCH, VERIFY and LOCKED. It SHALL change state only on valid words.
REQ-015 In SEARCH, on a valid word w with w[6:0] != 0, the block SHALL set s <= w[6:0] and go to VERIFY with match counter = 0. If w[6:0] == 0 it SHALL remain in SEARCH.
REQ-016 In VERIFY, each valid word SHALL be compared with the 8 bits predicted from s, and s SHALL advance 8 bits.
REQ-017 In VERIFY, on a match the match counter SHALL increment. On reaching LOCK_CNT the FSM SHALL go to LOCKED.
REQ-018 In VERIFY, any mismatch SHALL return the FSM to SEARCH and SHALL NOT update the counters.
REQ-019 In LOCKED, the predictor SHALL free-run on its own state (never reloaded from data_in). It SHALL advance 8 bits per valid word.
REQ-020 In LOCKED, on a mismatch the block SHALL assert err_pulse for the next cycle and increment word_err_cnt by 1. It SHALL add popcount(data_in ^ predicted) (1..8) to bit_err_cnt.
REQ-021 Both error counters SHALL saturate at 2^CNT_W-1 and SHALL never wrap. A bit_err_cnt add that would exceed the maximum SHALL clamp to it.
REQ-022 In LOCKED, UNLOCK_CNT consecutive errored words SHALL move the FSM to SEARCH. Any matching word SHALL reset the consecutive-error count.
REQ-023 The word that triggers unlock SHALL itself be counted.
REQ-024 locked SHALL be registered, rising one cycle after the LOCK_CNT-th matching word and falling one cycle after the unlocking word.
REQ-025 A data_valid-low cycle SHALL hold all state, and err_pulse SHALL be 0 in that cycle.
REQ-026 If clear_cnt and an error occur in the same cycle, the counters SHALL load the new error's contribution (1 word, popcount bits), not 0.
REQ-027 clear_cnt SHALL NOT affect the FSM or the predictor.

Reset
REQ-028 When reset is low at a clk edge, the block SHALL set FSM=SEARCH, s=7'h7F, match and consecutive-error counts=0, locked=0, err_pulse=0, and both counters=0.
REQ-029 Reset SHALL override data_valid and clear_cnt in the same cycle.
REQ-030 Reset asserted mid-LOCKED SHALL drop locked on the next edge, and relock SHALL require the full SEARCH/VERIFY sequence.

Configuration
REQ-031 When PRBS7_CHECKER_WORD_CNT_EN is defined, the block SHALL add output word_cnt, CNT_W bits. It SHALL be a saturating count of valid words received in LOCKED, reset to 0 and cleared by clear_cnt.
REQ-032 When PRBS7_CHECKER_WORD_CNT_EN is undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Package prbs_pkg SHALL hold the tap positions (6,5), the PRBS order 7, the word width 8, and the FSM state typedef {SEARCH, VERIFY, LOCKED}.
REQ-034 The combinational 8-bit advance (state in -> predicted word and next state) SHALL be sub-module prbs7_word_step. The same sub-module is reusable by the generator side.

Verification
REQ-035 The bench SHALL cover: reset low 2 cycles, then a clean PRBS7 stream from seed 7'h02, valid every cycle -> locked rises 1 cycle after the 5th valid word (1 SEARCH + 4 VERIFY); counters stay 0 over 100 words.
REQ-036 The bench SHALL cover: locked, flip bits 0 and 3 of one word -> err_pulse high 1 cycle, word_err_cnt=1, bit_err_cnt=2, locked stays 1.
REQ-037 The bench SHALL cover: locked, corrupt 3 consecutive words (1 bit each) -> word_err_cnt=3, locked falls after the 3rd; the clean stream then relocks after 5 more words.
REQ-038 The bench SHALL cover: CNT_W=4, locked, 3 words each with all 8 bits flipped but only 2 consecutive before a clean word -> bit_err_cnt saturates at 15; word_err_cnt=3.
REQ-039 The bench SHALL cover: clear_cnt in the same cycle as a 1-bit error -> word_err_cnt=1, bit_err_cnt=1.
REQ-040 The bench SHALL cover: data_valid toggled 1-of-3 cycles on a clean stream -> same lock behaviour counted in valid words; err_pulse never asserted.
